tomasulo_rs_mpy: RTL and testbench

- Reservation station in front of the multiply execution unit. Consumer of the CDB, producer of the issue interface.
- Accepts dispatched multiply ops whose operands may still be pending. Snoops the CDB to capture operand values as they broadcast.
- Issues the oldest fully-ready entry to the multiplier through iss_vld_r/iss_r, respecting the unit's busy indication.

---
 rtl/tomasulo_rs_mpy.sv | 235 +++++++++++++++++++++++
 tb/tb_tomasulo_rs_mpy.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rs_mpy.sv
// Reservation station for the multiply unit.
// Holds dispatched multiply ops until both operands are known. Operand values
// are captured by snooping the CDB. The oldest fully-ready entry is issued to
// the multiplier through a registered strobe/payload.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           drop every entry (pipeline flush)
//   dis_vld_i         dispatch request, taken only while dis_rdy_r_o=1
//   dis_rdy_r_o       at least one free entry (registered)
//   dis_wa_i          destination register
//   dis_tag_i         result tag broadcast by the multiplier
//   dis_robid_i       ROB id
//   dis_opr_rdy_i     per-operand value valid
//   dis_opr_data_i    operand values, [k] = operand k
//   dis_opr_tag_i     producer tags, [k] = operand k
//   cdb_i             completion bus {vld, tag, wdata}
//   exe_busy_i        multiplier busy
//   iss_vld_r_o       one-cycle issue strobe (registered)
//   iss_r_o           issue payload {rdata[1], rdata[0], wa, tag, robid}
//   occ_r_o           number of valid entries
module tomasulo_rs_mpy #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1),
    parameter int REG_W = 5,
    parameter int TAG_W = 6,
    parameter int ROB_W = 6,
    parameter int CDB_W = 1 + TAG_W + 32,
    parameter int ISS_W = 64 + REG_W + TAG_W + ROB_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  dis_vld_i,
    output logic                  dis_rdy_r_o,
    input  logic [REG_W-1:0]      dis_wa_i,
    input  logic [TAG_W-1:0]      dis_tag_i,
    input  logic [ROB_W-1:0]      dis_robid_i,
    input  logic [1:0]            dis_opr_rdy_i,
    input  logic [1:0][31:0]      dis_opr_data_i,
    input  logic [1:0][TAG_W-1:0] dis_opr_tag_i,
    input  logic [CDB_W-1:0]      cdb_i,
    input  logic                  exe_busy_i,
    output logic                  iss_vld_r_o,
    output logic [ISS_W-1:0]      iss_r_o,
    output logic [CNT_W-1:0]      occ_r_o
);

    // One extra age bit lets a modulo difference between any two live
    // entries (at most N-1 apart) be read as a signed value.
    localparam int AGE_W = $clog2(N) + 1;
    localparam int IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    logic                  vld_q   [N];
    logic                  vld_d   [N];
    logic [AGE_W-1:0]      age_q   [N];
    logic [AGE_W-1:0]      age_d   [N];
    logic [REG_W-1:0]      wa_q    [N];
    logic [REG_W-1:0]      wa_d    [N];
    logic [TAG_W-1:0]      tag_q   [N];
    logic [TAG_W-1:0]      tag_d   [N];
    logic [ROB_W-1:0]      rob_q   [N];
    logic [ROB_W-1:0]      rob_d   [N];
    logic [1:0]            ordy_q  [N];
    logic [1:0]            ordy_d  [N];
    logic [1:0][TAG_W-1:0] otag_q  [N];
    logic [1:0][TAG_W-1:0] otag_d  [N];
    logic [1:0][31:0]      odata_q [N];
    logic [1:0][31:0]      odata_d [N];

    logic [AGE_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             dis_rdy_q, dis_rdy_d;
    logic             iss_vld_q, iss_vld_d;
    logic [ISS_W-1:0] iss_q, iss_d;

    logic             cdb_vld;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_wdata;

    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [AGE_W-1:0] cand_age;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             iss_go;
    logic             dis_acc;

    assign {cdb_vld, cdb_tag, cdb_wdata} = cdb_i;

    // a is older than b when (b - a) mod 2^AGE_W is a small positive number.
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = b - a;
        return (diff != '0) && !diff[AGE_W-1];
    endfunction

    // Candidate selection and free-slot search both look at registered state
    // only, so a slot freed by issue is not refilled in the same cycle.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_age   = '0;
        for (int i = 0; i < N; i++) begin
            if (vld_q[i] && (ordy_q[i] == 2'b11)) begin
                if (!cand_found || older(age_q[i], cand_age)) begin
                    cand_found = 1'b1;
                    cand_idx   = IDX_W'(i);
                    cand_age   = age_q[i];
                end
            end
        end
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign iss_go  = cand_found && !exe_busy_i && !iss_vld_q && !flush_i;
    assign dis_acc = dis_vld_i && dis_rdy_q && free_found && !flush_i;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            vld_d[i]   = vld_q[i];
            age_d[i]   = age_q[i];
            wa_d[i]    = wa_q[i];
            tag_d[i]   = tag_q[i];
            rob_d[i]   = rob_q[i];
            ordy_d[i]  = ordy_q[i];
            otag_d[i]  = otag_q[i];
            odata_d[i] = odata_q[i];
        end
        seq_d     = seq_q;
        iss_vld_d = iss_go;
        iss_d     = iss_q;

        // Wakeup of stored operands; a match on an already-ready operand is ignored.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (vld_q[i] && !ordy_q[i][k] && cdb_vld && (otag_q[i][k] == cdb_tag)) begin
                    ordy_d[i][k]  = 1'b1;
                    odata_d[i][k] = cdb_wdata;
                end
            end
        end

        if (iss_go) begin
            vld_d[cand_idx] = 1'b0;
            iss_d = {odata_q[cand_idx][1], odata_q[cand_idx][0],
                     wa_q[cand_idx], tag_q[cand_idx], rob_q[cand_idx]};
        end

        if (dis_acc) begin
            vld_d[free_idx]  = 1'b1;
            age_d[free_idx]  = seq_q;
            seq_d            = seq_q + 1'b1;
            wa_d[free_idx]   = dis_wa_i;
            tag_d[free_idx]  = dis_tag_i;
            rob_d[free_idx]  = dis_robid_i;
            otag_d[free_idx] = dis_opr_tag_i;
            for (int k = 0; k < 2; k++) begin
                // Bypass: a same-cycle CDB broadcast resolves a pending operand.
                if (dis_opr_rdy_i[k]) begin
                    ordy_d[free_idx][k]  = 1'b1;
                    odata_d[free_idx][k] = dis_opr_data_i[k];
                end else if (cdb_vld && (dis_opr_tag_i[k] == cdb_tag)) begin
                    ordy_d[free_idx][k]  = 1'b1;
                    odata_d[free_idx][k] = cdb_wdata;
                end else begin
                    ordy_d[free_idx][k]  = 1'b0;
                    odata_d[free_idx][k] = dis_opr_data_i[k];
                end
            end
        end

        occ_d = occ_q + CNT_W'(dis_acc) - CNT_W'(iss_go);

        if (flush_i) begin
            for (int i = 0; i < N; i++) begin
                vld_d[i] = 1'b0;
            end
            occ_d     = '0;
            iss_vld_d = 1'b0;
        end

        dis_rdy_d = (occ_d < N_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                vld_q[i]   <= 1'b0;
                age_q[i]   <= '0;
                wa_q[i]    <= '0;
                tag_q[i]   <= '0;
                rob_q[i]   <= '0;
                ordy_q[i]  <= '0;
                otag_q[i]  <= '0;
                odata_q[i] <= '0;
            end
            seq_q     <= '0;
            occ_q     <= '0;
            dis_rdy_q <= 1'b1;
            iss_vld_q <= 1'b0;
            iss_q     <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                vld_q[i]   <= vld_d[i];
                age_q[i]   <= age_d[i];
                wa_q[i]    <= wa_d[i];
                tag_q[i]   <= tag_d[i];
                rob_q[i]   <= rob_d[i];
                ordy_q[i]  <= ordy_d[i];
                otag_q[i]  <= otag_d[i];
                odata_q[i] <= odata_d[i];
            end
            seq_q     <= seq_d;
            occ_q     <= occ_d;
            dis_rdy_q <= dis_rdy_d;
            iss_vld_q <= iss_vld_d;
            iss_q     <= iss_d;
        end
    end

    assign dis_rdy_r_o = dis_rdy_q;
    assign iss_vld_r_o = iss_vld_q;
    assign iss_r_o     = iss_q;
    assign occ_r_o     = occ_q;

endmodule

// File: tb/tb_tomasulo_rs_mpy.sv
// Bench for tomasulo_rs_mpy: an age-ordered queue model predicts the outputs
// every cycle, and directed scenarios pin literal expected values.
module tb_tomasulo_rs_mpy;

    localparam int N     = 4;
    localparam int CNT_W = $clog2(N + 1);
    localparam int REG_W = 5;
    localparam int TAG_W = 6;
    localparam int ROB_W = 6;
    localparam int CDB_W = 1 + TAG_W + 32;
    localparam int ISS_W = 64 + REG_W + TAG_W + ROB_W;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  dis_vld;
    logic                  dis_rdy;
    logic [REG_W-1:0]      dis_wa;
    logic [TAG_W-1:0]      dis_tag;
    logic [ROB_W-1:0]      dis_robid;
    logic [1:0]            dis_opr_rdy;
    logic [1:0][31:0]      dis_opr_data;
    logic [1:0][TAG_W-1:0] dis_opr_tag;
    logic                  cdb_vld;
    logic [TAG_W-1:0]      cdb_tag;
    logic [31:0]           cdb_wdata;
    logic [CDB_W-1:0]      cdb;
    logic                  exe_busy;
    logic                  iss_vld;
    logic [ISS_W-1:0]      iss_r;
    logic [CNT_W-1:0]      occ;

    assign cdb = {cdb_vld, cdb_tag, cdb_wdata};

    tomasulo_rs_mpy #(.N(N), .REG_W(REG_W), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .dis_vld_i      (dis_vld),
        .dis_rdy_r_o    (dis_rdy),
        .dis_wa_i       (dis_wa),
        .dis_tag_i      (dis_tag),
        .dis_robid_i    (dis_robid),
        .dis_opr_rdy_i  (dis_opr_rdy),
        .dis_opr_data_i (dis_opr_data),
        .dis_opr_tag_i  (dis_opr_tag),
        .cdb_i          (cdb),
        .exe_busy_i     (exe_busy),
        .iss_vld_r_o    (iss_vld),
        .iss_r_o        (iss_r),
        .occ_r_o        (occ)
    );

    wire [31:0]      d_rd1 = iss_r[ISS_W-1 -: 32];
    wire [31:0]      d_rd0 = iss_r[ISS_W-33 -: 32];
    wire [REG_W-1:0] d_wa  = iss_r[REG_W+TAG_W+ROB_W-1 -: REG_W];
    wire [TAG_W-1:0] d_tag = iss_r[TAG_W+ROB_W-1 -: TAG_W];
    wire [ROB_W-1:0] d_rob = iss_r[ROB_W-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]            rdy;
        logic [1:0][TAG_W-1:0] t;
        logic [1:0][31:0]      d;
        logic [REG_W-1:0]      wa;
        logic [TAG_W-1:0]      tag;
        logic [ROB_W-1:0]      rob;
    } ent_t;

    ent_t             q[$];  // index 0 is the oldest
    logic             m_vld;
    logic [31:0]      m_rd0, m_rd1;
    logic [REG_W-1:0] m_wa;
    logic [TAG_W-1:0] m_tag;
    logic [ROB_W-1:0] m_rob;
    int               m_cand;
    bit               m_iss, m_dis;
    ent_t             m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_vld = 1'b0;
            m_rd0 = '0; m_rd1 = '0; m_wa = '0; m_tag = '0; m_rob = '0;
        end else begin
            if (dis_vld) begin
                n_cmp++;
                if (q.size() >= N && !flush) begin
                    n_bad++;
                    $display("FAIL protocol: dispatch with occ=%0d, required below %0d", q.size(), N);
                end
            end
            m_cand = -1;
            for (int i = 0; i < q.size(); i++)
                if (m_cand < 0 && q[i].rdy == 2'b11) m_cand = i;
            m_iss = (m_cand >= 0) && !exe_busy && !m_vld && !flush;
            m_dis = dis_vld && (q.size() < N) && !flush;
            if (flush) begin
                q.delete();
                m_vld = 1'b0;
            end else begin
                m_vld = m_iss;
                if (m_iss) begin
                    m_rd0 = q[m_cand].d[0];
                    m_rd1 = q[m_cand].d[1];
                    m_wa  = q[m_cand].wa;
                    m_tag = q[m_cand].tag;
                    m_rob = q[m_cand].rob;
                    q.delete(m_cand);
                end
                for (int i = 0; i < q.size(); i++) begin
                    m_e = q[i];
                    for (int k = 0; k < 2; k++)
                        if (cdb_vld && !m_e.rdy[k] && m_e.t[k] == cdb_tag) begin
                            m_e.rdy[k] = 1'b1;
                            m_e.d[k]   = cdb_wdata;
                        end
                    q[i] = m_e;
                end
                if (m_dis) begin
                    m_e.wa  = dis_wa;
                    m_e.tag = dis_tag;
                    m_e.rob = dis_robid;
                    m_e.t   = dis_opr_tag;
                    for (int k = 0; k < 2; k++) begin
                        if (dis_opr_rdy[k]) begin
                            m_e.rdy[k] = 1'b1; m_e.d[k] = dis_opr_data[k];
                        end else if (cdb_vld && dis_opr_tag[k] == cdb_tag) begin
                            m_e.rdy[k] = 1'b1; m_e.d[k] = cdb_wdata;
                        end else begin
                            m_e.rdy[k] = 1'b0; m_e.d[k] = '0;
                        end
                    end
                    q.push_back(m_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("iss_vld",  64'(iss_vld), 64'(m_vld));
            chk("occ",      64'(occ), 64'(q.size()));
            chk("dis_rdy",  64'(dis_rdy), 64'(q.size() < N));
            chk("iss_wa",   64'(d_wa), 64'(m_wa));
            chk("iss_tag",  64'(d_tag), 64'(m_tag));
            chk("iss_rob",  64'(d_rob), 64'(m_rob));
            if (m_vld) begin
                chk("iss_rd0", 64'(d_rd0), 64'(m_rd0));
                chk("iss_rd1", 64'(d_rd1), 64'(m_rd1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_vld = 1'b1; cdb_tag = t; cdb_wdata = d;
    endtask

    task automatic clr_cdb();
        cdb_vld = 1'b0; cdb_tag = '0; cdb_wdata = '0;
    endtask

    // Sets dispatch inputs; the caller decides when the edge happens.
    task automatic set_dis(input logic [31:0] d0, input logic r0, input logic [TAG_W-1:0] t0,
                           input logic [31:0] d1, input logic r1, input logic [TAG_W-1:0] t1,
                           input logic [REG_W-1:0] wa, input logic [TAG_W-1:0] tg,
                           input logic [ROB_W-1:0] rob);
        dis_vld = 1'b1;
        dis_opr_data[0] = d0; dis_opr_rdy[0] = r0; dis_opr_tag[0] = t0;
        dis_opr_data[1] = d1; dis_opr_rdy[1] = r1; dis_opr_tag[1] = t1;
        dis_wa = wa; dis_tag = tg; dis_robid = rob;
    endtask

    task automatic clr_dis();
        dis_vld = 1'b0; dis_opr_rdy = '0; dis_opr_data = '0; dis_opr_tag = '0;
        dis_wa = '0; dis_tag = '0; dis_robid = '0;
    endtask

    task automatic dispatch(input logic [31:0] d0, input logic r0, input logic [TAG_W-1:0] t0,
                            input logic [31:0] d1, input logic r1, input logic [TAG_W-1:0] t1,
                            input logic [REG_W-1:0] wa, input logic [TAG_W-1:0] tg,
                            input logic [ROB_W-1:0] rob);
        set_dis(d0, r0, t0, d1, r1, t1, wa, tg, rob);
        tick();
        clr_dis();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; exe_busy = 1'b0;
        clr_dis();
        clr_cdb();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_occ",     64'(occ), 64'd0);
        chk("rst_dis_rdy", 64'(dis_rdy), 64'd1);
        chk("rst_iss_vld", 64'(iss_vld), 64'd0);
        chk("rst_iss_r",   64'(iss_r == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Ready dispatch
        dispatch(32'd3, 1, 0, 32'd5, 1, 0, 5'd7, 6'd2, 6'd1);
        chk("rd_occ1", 64'(occ), 64'd1);
        chk("rd_novld", 64'(iss_vld), 64'd0);
        tick();
        chk("rd_vld", 64'(iss_vld), 64'd1);
        chk("rd_rd0", 64'(d_rd0), 64'd3);
        chk("rd_rd1", 64'(d_rd1), 64'd5);
        chk("rd_tag", 64'(d_tag), 64'd2);
        chk("rd_rob", 64'(d_rob), 64'd1);
        chk("rd_occ0", 64'(occ), 64'd0);
        tick();
        chk("rd_pulse", 64'(iss_vld), 64'd0);

        // Wakeup from CDB
        dispatch(32'd7, 1, 0, 32'd0, 0, 6'd9, 5'd3, 6'd5, 6'd2);
        tick();
        tick();
        set_cdb(6'd9, 32'h10);
        tick();
        clr_cdb();
        chk("wk_not_yet", 64'(iss_vld), 64'd0);
        tick();
        chk("wk_vld", 64'(iss_vld), 64'd1);
        chk("wk_rd1", 64'(d_rd1), 64'h10);
        chk("wk_rd0", 64'(d_rd0), 64'd7);
        tick();

        // Dispatch bypass
        set_cdb(6'd4, 32'hAB);
        dispatch(32'h11, 1, 0, 32'd0, 0, 6'd4, 5'd1, 6'd6, 6'd3);
        clr_cdb();
        chk("bp_occ", 64'(occ), 64'd1);
        tick();
        chk("bp_vld", 64'(iss_vld), 64'd1);
        chk("bp_rd1", 64'(d_rd1), 64'hAB);
        chk("bp_rob", 64'(d_rob), 64'd3);
        tick();

        // Full and ordering
        exe_busy = 1'b1;
        for (int k = 0; k < N; k++)
            dispatch(32'(k + 1), 1, 0, 32'((k + 1) * 2), 1, 0, 5'(k), 6'(10 + k), 6'(10 + k));
        chk("full_occ", 64'(occ), 64'd4);
        chk("full_rdy", 64'(dis_rdy), 64'd0);
        chk("full_novld", 64'(iss_vld), 64'd0);
        exe_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("ord_vld", 64'(iss_vld), 64'd1);
            chk("ord_rob", 64'(d_rob), 64'(10 + k));
            if (k == 0) begin
                chk("ord_rdy_back", 64'(dis_rdy), 64'd1);
                chk("ord_occ3", 64'(occ), 64'd3);
            end
            tick();
            chk("ord_gap", 64'(iss_vld), 64'd0);
        end

        // Younger wakes first, busy gating
        dispatch(32'd1, 1, 0, 32'd0, 0, 6'd20, 5'd2, 6'd20, 6'd20);
        dispatch(32'd2, 1, 0, 32'd0, 0, 6'd21, 5'd2, 6'd21, 6'd21);
        set_cdb(6'd21, 32'h55);
        exe_busy = 1'b1;
        tick();
        clr_cdb();
        tick();
        chk("busy_hold", 64'(iss_vld), 64'd0);
        exe_busy = 1'b0;
        tick();
        chk("ooo_vld", 64'(iss_vld), 64'd1);
        chk("ooo_rob", 64'(d_rob), 64'd21);
        chk("ooo_rd1", 64'(d_rd1), 64'h55);
        set_cdb(6'd20, 32'h66);
        tick();
        clr_cdb();
        tick();
        chk("ooo2_rob", 64'(d_rob), 64'd20);
        chk("ooo2_rd1", 64'(d_rd1), 64'h66);
        tick();

        // Dispatch + issue + CDB in one cycle
        exe_busy = 1'b1;
        dispatch(32'd4, 1, 0, 32'd0, 0, 6'd40, 5'd4, 6'd30, 6'd30);
        dispatch(32'd6, 1, 0, 32'd8, 1, 0, 5'd4, 6'd31, 6'd31);
        exe_busy = 1'b0;
        set_cdb(6'd40, 32'h77);
        dispatch(32'd9, 1, 0, 32'd0, 0, 6'd40, 5'd4, 6'd32, 6'd32);
        clr_cdb();
        chk("all_occ", 64'(occ), 64'd2);
        chk("all_rob", 64'(d_rob), 64'd31);
        tick();
        tick();
        chk("all2_rob", 64'(d_rob), 64'd30);
        chk("all2_rd1", 64'(d_rd1), 64'h77);
        tick();
        tick();
        chk("all3_rob", 64'(d_rob), 64'd32);
        chk("all3_rd1", 64'(d_rd1), 64'h77);
        tick();

        // Flush with a same-cycle dispatch and a ready candidate
        exe_busy = 1'b1;
        dispatch(32'd9, 1, 0, 32'd8, 1, 0, 5'd6, 6'd40, 6'd40);
        dispatch(32'd0, 0, 6'd50, 32'd1, 1, 0, 5'd6, 6'd41, 6'd41);
        dispatch(32'd0, 0, 6'd51, 32'd1, 1, 0, 5'd6, 6'd42, 6'd42);
        chk("fl_occ3", 64'(occ), 64'd3);
        exe_busy = 1'b0;
        flush = 1'b1;
        set_dis(32'd1, 1, 0, 32'd1, 1, 0, 5'd6, 6'd43, 6'd43);
        tick();
        flush = 1'b0;
        clr_dis();
        chk("fl_occ0", 64'(occ), 64'd0);
        chk("fl_rdy", 64'(dis_rdy), 64'd1);
        chk("fl_novld", 64'(iss_vld), 64'd0);
        set_cdb(6'd50, 32'h99);
        tick();
        clr_cdb();
        tick();
        chk("fl_after_vld", 64'(iss_vld), 64'd0);
        chk("fl_after_occ", 64'(occ), 64'd0);

        // Asynchronous reset during an issue strobe
        dispatch(32'h21, 1, 0, 32'h22, 1, 0, 5'd9, 6'd44, 6'd50);
        tick();
        chk("ar_vld_before", 64'(iss_vld), 64'd1);
        rst = 1'b1;
        #1;
        chk("ar_vld", 64'(iss_vld), 64'd0);
        chk("ar_occ", 64'(occ), 64'd0);
        chk("ar_rdy", 64'(dis_rdy), 64'd1);
        chk("ar_iss_r", 64'(iss_r == '0), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        dispatch(32'h2, 1, 0, 32'h3, 1, 0, 5'd9, 6'd45, 6'd51);
        tick();
        chk("ar_resume_rob", 64'(d_rob), 64'd51);
        chk("ar_resume_vld", 64'(iss_vld), 64'd1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
